// File: rtl/pipeline_stall_ctrl.sv
// Pipeline hazard/stall controller: Mealy stage enables and flushes, plus a multi-cycle wait timer.
// Optional STALL_PERF_CNT_EN adds stall_cycles / flush_events counters.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | normal flow, arbitrates dmem_wait > mc_start > redirect > load-use
// MEM_WAIT  | data memory not ready, whole pipe frozen
// MC_WAIT   | mul/div in EX, front end held, EX/MEM gets bubbles
// LU_BUBBLE | one bubble injected for a load-use hazard
module pipeline_stall_ctrl #(
  parameter int MC_MAX = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ld_use_hazard,
  input  logic       ctrl_redirect,
  input  logic       mc_start,
  input  logic       mc_done,
  input  logic       dmem_wait,
  output logic       pc_we,
  output logic       if_id_we,
  output logic       id_ex_we,
  output logic       ex_mem_we,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_flush,
  output logic [1:0] state,
  output logic       mc_timeout
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    MEM_WAIT  = 2'b01,
    MC_WAIT   = 2'b10,
    LU_BUBBLE = 2'b11
  } state_t;

  localparam logic [6:0] MC_MAX_C = 7'(MC_MAX);

  state_t     state_q, state_nxt;
  logic [6:0] cnt_q, cnt_nxt;
  logic       tmo_nxt;
  logic       run_like;

  assign state = state_q;

  // MEM_WAIT with memory ready behaves exactly like RUN, so both share one decode.
  assign run_like = (state_q == RUN) || ((state_q == MEM_WAIT) && !dmem_wait);

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    id_ex_we     = 1'b1;
    ex_mem_we    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    state_nxt    = state_q;
    cnt_nxt      = cnt_q;
    tmo_nxt      = 1'b0;

    if (run_like) begin
      if (dmem_wait) begin
        pc_we     = 1'b0;
        if_id_we  = 1'b0;
        id_ex_we  = 1'b0;
        ex_mem_we = 1'b0;
        state_nxt = MEM_WAIT;
      end else if (mc_start) begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_we     = 1'b0;
        ex_mem_flush = 1'b1;
        cnt_nxt      = 7'd1;
        state_nxt    = MC_WAIT;
      end else if (ctrl_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_nxt   = RUN;
      end else if (ld_use_hazard) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
        state_nxt   = LU_BUBBLE;
      end else begin
        state_nxt = RUN;
      end
    end else if (dmem_wait) begin
      // Memory stall freezes MC_WAIT / LU_BUBBLE in place, timer included.
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
    end else if (state_q == MC_WAIT) begin
      if (mc_done) begin
        cnt_nxt   = 7'd0;
        state_nxt = RUN;
      end else begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_we     = 1'b0;
        ex_mem_flush = 1'b1;
        if (cnt_q == MC_MAX_C) begin
          tmo_nxt   = 1'b1;
          cnt_nxt   = 7'd0;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt_q + 7'd1;
        end
      end
    end else begin
      if (ctrl_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      state_nxt = RUN;
    end

    if (!rstn) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= RUN;
      cnt_q      <= 7'd0;
      mc_timeout <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      mc_timeout <= tmo_nxt;
    end
  end

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      if (!pc_we)      stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_stall_ctrl;

  localparam int TB_MC_MAX = 5;

  localparam logic [6:0] O_DEF   = 7'b1111_000;
  localparam logic [6:0] O_FRZ   = 7'b0000_000;
  localparam logic [6:0] O_RST   = 7'b0000_111;
  localparam logic [6:0] O_LU    = 7'b0011_010;
  localparam logic [6:0] O_MC    = 7'b0001_001;
  localparam logic [6:0] O_REDIR = 7'b1111_110;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic ld_use_hazard = 1'b0, ctrl_redirect = 1'b0, mc_start = 1'b0, mc_done = 1'b0, dmem_wait = 1'b0;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0] state;
  logic mc_timeout;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: mode uses the externally visible state encoding, waited counts MC_WAIT cycles.
  bit          m_valid = 0;
  int          m_mode  = 0;
  int          m_waited = 0;
  bit          m_tmo   = 0;
  logic [31:0] m_stall = 0;
  logic [31:0] m_flush = 0;

  pipeline_stall_ctrl #(.MC_MAX(TB_MC_MAX)) dut (
    .clk(clk), .rstn(rstn),
    .ld_use_hazard(ld_use_hazard), .ctrl_redirect(ctrl_redirect),
    .mc_start(mc_start), .mc_done(mc_done), .dmem_wait(dmem_wait),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .state(state), .mc_timeout(mc_timeout)
`ifdef STALL_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  always #5 clk = ~clk;

  wire [6:0] dut_o = {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, ex_mem_flush};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Spec rules for one cycle with rstn high.
  function automatic void model_eval(input int mode, input int waited,
                                     input bit ld, input bit rd, input bit st, input bit dn, input bit dw,
                                     output logic [6:0] o, output int nmode, output int nwaited,
                                     output bit tmo);
    o = O_DEF; nmode = mode; nwaited = waited; tmo = 0;
    if (mode == 0 || (mode == 1 && !dw)) begin
      if (dw)      begin o = O_FRZ;   nmode = 1; end
      else if (st) begin o = O_MC;    nmode = 2; nwaited = 1; end
      else if (rd) begin o = O_REDIR; nmode = 0; end
      else if (ld) begin o = O_LU;    nmode = 3; end
      else nmode = 0;
    end else if (dw) begin
      o = O_FRZ;
    end else if (mode == 2) begin
      if (dn) nmode = 0;
      else begin
        o = O_MC;
        if (waited >= TB_MC_MAX) begin nmode = 0; tmo = 1; end
        else nwaited = waited + 1;
      end
    end else begin
      o = rd ? O_REDIR : O_DEF;
      nmode = 0;
    end
  endfunction

  // One clock cycle: drive after negedge, compare with the model, then advance the model over the posedge.
  task automatic step(input bit r, input bit ld, input bit rd, input bit st, input bit dn, input bit dw);
    logic [6:0] o;
    int nm, nw;
    bit tmo;
    @(negedge clk);
    rstn = r; ld_use_hazard = ld; ctrl_redirect = rd; mc_start = st; mc_done = dn; dmem_wait = dw;
    #1;
    model_eval(m_mode, m_waited, ld, rd, st, dn, dw, o, nm, nw, tmo);
    if (!r) o = O_RST;
    if (!r || m_valid) chk("outputs", 32'(dut_o), 32'(o));
    if (m_valid) begin
      chk("state", 32'(state), 32'(m_mode));
      chk("mc_timeout", 32'(mc_timeout), 32'(m_tmo));
`ifdef STALL_PERF_CNT_EN
      chk("stall_cycles", stall_cycles, m_stall);
      chk("flush_events", flush_events, m_flush);
`endif
    end
    if (!r) begin
      m_valid = 1; m_mode = 0; m_waited = 0; m_tmo = 0; m_stall = 0; m_flush = 0;
    end else if (m_valid) begin
      if (!o[6]) m_stall = m_stall + 32'd1;
      if (o[2])  m_flush = m_flush + 32'd1;
      m_mode = nm; m_waited = nw; m_tmo = tmo;
    end
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1);
    chk("reset_outputs", 32'(dut_o), 32'(O_RST));
    idle();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_default_out", 32'(dut_o), 32'(O_DEF));
    chk("reset_tmo", 32'(mc_timeout), 32'd0);

    // Load-use hazard held two cycles
    step(1, 1, 0, 0, 0, 0);
    chk("lu_c0_out", 32'(dut_o), 32'(O_LU));
    step(1, 1, 0, 0, 0, 0);
    chk("lu_c1_state", 32'(state), 32'd3);
    chk("lu_c1_out", 32'(dut_o), 32'(O_DEF));
    idle();
    chk("lu_c2_state", 32'(state), 32'd0);

    // mc_done on the fifth MC_WAIT cycle, which is also the counter==MC_MAX cycle
    step(1, 0, 0, 1, 0, 0);
    chk("mc_start_out", 32'(dut_o), 32'(O_MC));
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 0, 0, 0);
      chk("mc_wait_state", 32'(state), 32'd2);
      chk("mc_wait_out", 32'(dut_o), 32'(O_MC));
    end
    step(1, 0, 0, 0, 1, 0);
    chk("mc_done_state", 32'(state), 32'd2);
    chk("mc_done_out", 32'(dut_o), 32'(O_DEF));
    idle();
    chk("mc_done_run", 32'(state), 32'd0);
    chk("mc_done_no_tmo", 32'(mc_timeout), 32'd0);

    // Timeout after MC_MAX wait cycles
    step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < TB_MC_MAX; i++) begin
      idle();
      chk("tmo_wait_out", 32'(dut_o), 32'(O_MC));
    end
    idle();
    chk("tmo_state", 32'(state), 32'd0);
    chk("tmo_pulse", 32'(mc_timeout), 32'd1);
    idle();
    chk("tmo_pulse_end", 32'(mc_timeout), 32'd0);

    // dmem_wait beats mc_start and redirect; released with mc_start still high
    step(1, 0, 1, 1, 0, 1);
    chk("prio_out", 32'(dut_o), 32'(O_FRZ));
    step(1, 0, 0, 1, 0, 1);
    chk("memwait_state", 32'(state), 32'd1);
    chk("memwait_out", 32'(dut_o), 32'(O_FRZ));
    step(1, 0, 0, 1, 0, 0);
    chk("memwait_release_out", 32'(dut_o), 32'(O_MC));
    idle();
    chk("memwait_to_mc", 32'(state), 32'd2);
    step(1, 0, 0, 0, 1, 0);
    idle();

    // Reset pulse mid-MC_WAIT
    step(1, 0, 0, 1, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 0);
    chk("midrst_out", 32'(dut_o), 32'(O_RST));
    idle();
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_out_after", 32'(dut_o), 32'(O_DEF));

`ifdef STALL_PERF_CNT_EN
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 0, 0);
      idle();
    end
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    idle();
    chk("perf_stall", stall_cycles, 32'd3);
    chk("perf_flush", flush_events, 32'd2);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(99) >= 2,
           $urandom_range(99) < 20,
           $urandom_range(99) < 20,
           $urandom_range(99) < 15,
           $urandom_range(99) < 12,
           $urandom_range(99) < 18);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
